// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - ROM request/return and decode handshake bundle for fetch_queue
interface fetch_queue_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 15,
    parameter int DEPTH   = 4
);
    logic [PC_W-1:0]              rom_addr;
    logic                         rom_req;
    logic [INSTR_W-1:0]           rom_data;
    logic                         redirect;
    logic [PC_W-1:0]              redirect_pc;
    logic                         hold;
    logic                         instr_valid;
    logic [INSTR_W-1:0]           instr;
    logic [PC_W-1:0]              instr_pc;
    logic                         instr_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // master is the prefetch unit; slave is the ROM/execute/decode side
    modport master (
        output rom_addr, rom_req, instr_valid, instr, instr_pc, count,
        input  rom_data, redirect, redirect_pc, hold, instr_ready
    );
    modport slave (
        input  rom_addr, rom_req, instr_valid, instr, instr_pc, count,
        output rom_data, redirect, redirect_pc, hold, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator plus DEPTH-entry instruction queue between ROM and decode
module fetch_queue #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 15,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(12'o4000)
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic [PC_W-1:0]    mem_pc_q    [DEPTH];

    logic               valid;
    logic               pop;
    logic               push;
    logic               req;
    logic [CW:0]        occupancy;

    assign valid = (count_q != '0) & ~bus.redirect;
    assign pop   = valid & bus.instr_ready;
    assign push  = inflight_q & ~bus.redirect;

    // Credits cover both queued entries and the word still in the ROM pipe,
    // so a landing word always has a free slot.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign req       = ~bus.redirect & ~bus.hold & (occupancy < (CW+1)'(DEPTH));

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.rom_req     = req;
    assign bus.instr_valid = valid;
    assign bus.instr       = mem_instr_q[rd_ptr_q];
    assign bus.instr_pc    = mem_pc_q[rd_ptr_q];
    assign bus.count       = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (req) begin
            fetch_pc_d    = fetch_pc_q + PC_W'(1);
            inflight_pc_d = fetch_pc_q;
        end
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            if (push) begin
                mem_instr_q[wr_ptr_q] <= bus.rom_data;
                mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table and sequence checks for fetch_queue at DEPTH 4 and 2
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        hold = 1'b0;
    logic        ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue_if #(.PC_W(12), .INSTR_W(15), .DEPTH(4)) ifa ();
    fetch_queue_if #(.PC_W(12), .INSTR_W(15), .DEPTH(2)) ifb ();

    fetch_queue #(.PC_W(12), .INSTR_W(15), .DEPTH(4)) u_d4 (.clock(clock), .reset_n(reset_n), .bus(ifa));
    fetch_queue #(.PC_W(12), .INSTR_W(15), .DEPTH(2)) u_d2 (.clock(clock), .reset_n(reset_n), .bus(ifb));

    assign ifa.redirect = redirect;  assign ifb.redirect = redirect;
    assign ifa.redirect_pc = redirect_pc;  assign ifb.redirect_pc = redirect_pc;
    assign ifa.hold = hold;  assign ifb.hold = hold;
    assign ifa.instr_ready = ready;  assign ifb.instr_ready = ready;

    always #5 clock = ~clock;

    function automatic logic [14:0] rom_fn(input logic [11:0] a);
        return {a[2:0] ^ 3'b110, a ^ 12'o5252};
    endfunction

    // synchronous 1-cycle ROM: data answers the address presented last cycle
    always @(posedge clock) begin
        ifa.rom_data <= rom_fn(ifa.rom_addr);
        ifb.rom_data <= rom_fn(ifb.rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'o%0o expected 'o%0o", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rd, input logic [11:0] rpc, input logic hd, input logic rdy);
        @(negedge clock);
        redirect = rd; redirect_pc = rpc; hold = hd; ready = rdy;
        #1;
    endtask

    task automatic rst_release(input logic rdy);
        @(negedge clock);
        reset_n = 1'b0; redirect = 1'b0; hold = 1'b0; ready = rdy;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        rd;
        logic [11:0] rpc;
        logic        hd;
        logic        rdy;
        logic        e_valid;
        logic [11:0] e_pc;
        logic        e_req;
        logic [11:0] e_addr;
        logic [2:0]  e_count;
    } vec_t;

    vec_t        tbl [10];
    int          nreq;
    logic [11:0] exp_pc;
    logic [11:0] wrap_pcs [4];
    logic        seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // row 0 under reset, rows 1..9 are cycles 0..8 after release
        tbl[0] = '{1'b0, 1'b0, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0, 1'b1, 12'o4000, 3'd0};
        for (int k = 0; k < 9; k++) begin
            tbl[k+1] = '{1'b1, 1'b0, 12'o0, 1'b0, 1'b1, (k >= 2), 12'o4000 + 12'(k - 2),
                         1'b1, 12'o4000 + 12'(k), (k >= 2) ? 3'd1 : 3'd0};
        end
        wrap_pcs[0] = 12'o7776; wrap_pcs[1] = 12'o7777; wrap_pcs[2] = 12'o0000; wrap_pcs[3] = 12'o0001;

        // reset release and steady stream, both depths
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            reset_n = tbl[i].rst_n; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
            hold = tbl[i].hd; ready = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_valid", i), 32'(ifa.instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t%0d_req", i), 32'(ifa.rom_req), 32'(tbl[i].e_req));
            chk($sformatf("t%0d_addr", i), 32'(ifa.rom_addr), 32'(tbl[i].e_addr));
            chk($sformatf("t%0d_count", i), 32'(ifa.count), 32'(tbl[i].e_count));
            chk($sformatf("t%0d_d2_valid", i), 32'(ifb.instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i), 32'(ifa.instr_pc), 32'(tbl[i].e_pc));
                chk($sformatf("t%0d_instr", i), 32'(ifa.instr), 32'(rom_fn(tbl[i].e_pc)));
                chk($sformatf("t%0d_d2_pc", i), 32'(ifb.instr_pc), 32'(tbl[i].e_pc));
                chk($sformatf("t%0d_d2_instr", i), 32'(ifb.instr), 32'(rom_fn(tbl[i].e_pc)));
            end else if (!tbl[i].rst_n) begin
                chk("rst_instr", 32'(ifa.instr), 32'd0);
                chk("rst_instr_pc", 32'(ifa.instr_pc), 32'd0);
            end
        end

        // decode stalled: exactly DEPTH requests, then resume without gap
        rst_release(1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc(1'b0, 12'o0, 1'b0, 1'b0);
            nreq += int'(ifa.rom_req);
        end
        chk("stall_nreq", 32'(nreq), 32'd4);
        chk("stall_count", 32'(ifa.count), 32'd4);
        chk("stall_req", 32'(ifa.rom_req), 32'd0);
        exp_pc = 12'o4000;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 12'o0, 1'b0, 1'b1);
            if (i == 0) chk("resume_req", 32'(ifa.rom_req), 32'd1);
            chk("resume_valid", 32'(ifa.instr_valid), 32'd1);
            chk("resume_pc", 32'(ifa.instr_pc), 32'(exp_pc));
            chk("resume_instr", 32'(ifa.instr), 32'(rom_fn(exp_pc)));
            exp_pc = exp_pc + 12'd1;
        end

        // redirect with count 3 and a word in flight
        rst_release(1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 12'o0, 1'b0, 1'b0);
        cyc(1'b1, 12'o2000, 1'b0, 1'b0);
        chk("rd_r_count", 32'(ifa.count), 32'd3);
        chk("rd_r_valid", 32'(ifa.instr_valid), 32'd0);
        chk("rd_r_req", 32'(ifa.rom_req), 32'd0);
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("rd_r1_count", 32'(ifa.count), 32'd0);
        chk("rd_r1_valid", 32'(ifa.instr_valid), 32'd0);
        chk("rd_r1_addr", 32'(ifa.rom_addr), 32'o2000);
        chk("rd_r1_req", 32'(ifa.rom_req), 32'd1);
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("rd_r2_valid", 32'(ifa.instr_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 12'o0, 1'b0, 1'b1);
            chk("rd_valid", 32'(ifa.instr_valid), 32'd1);
            chk("rd_pc", 32'(ifa.instr_pc), 32'o2000 + 32'(k));
            chk("rd_instr", 32'(ifa.instr), 32'(rom_fn(12'o2000 + 12'(k))));
        end

        // redirect across the PC wrap
        cyc(1'b1, 12'o7776, 1'b0, 1'b1);
        chk("wrap_r_valid", 32'(ifa.instr_valid), 32'd0);
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("wrap_r1_valid", 32'(ifa.instr_valid), 32'd0);
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("wrap_r2_valid", 32'(ifa.instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 12'o0, 1'b0, 1'b1);
            chk("wrap_valid", 32'(ifa.instr_valid), 32'd1);
            chk("wrap_pc", 32'(ifa.instr_pc), 32'(wrap_pcs[k]));
        end

        // hold from a steady stream: in-flight 'o0004 lands, queue drains
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("hold_pre_pc", 32'(ifa.instr_pc), 32'o0002);
        cyc(1'b0, 12'o0, 1'b1, 1'b1);
        chk("hold_h_req", 32'(ifa.rom_req), 32'd0);
        chk("hold_h_pc", 32'(ifa.instr_pc), 32'o0003);
        cyc(1'b0, 12'o0, 1'b1, 1'b1);
        chk("hold_land_valid", 32'(ifa.instr_valid), 32'd1);
        chk("hold_land_pc", 32'(ifa.instr_pc), 32'o0004);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 12'o0, 1'b1, 1'b1);
            chk("hold_count", 32'(ifa.count), 32'd0);
            chk("hold_req", 32'(ifa.rom_req), 32'd0);
        end
        cyc(1'b0, 12'o0, 1'b0, 1'b1);
        chk("hold_rel_req", 32'(ifa.rom_req), 32'd1);
        chk("hold_rel_addr", 32'(ifa.rom_addr), 32'o0005);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            cyc(1'b0, 12'o0, 1'b0, 1'b1);
            if (ifa.instr_valid) begin
                seen = 1'b1;
                chk("hold_next_pc", 32'(ifa.instr_pc), 32'o0005);
            end
        end
        chk("hold_next_seen", 32'(seen), 32'd1);

        // asynchronous reset mid-stream with three entries queued
        rst_release(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 12'o0, 1'b0, 1'b0);
        chk("areset_pre_count", 32'(ifa.count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", 32'(ifa.instr_valid), 32'd0);
        chk("areset_count", 32'(ifa.count), 32'd0);
        chk("areset_addr", 32'(ifa.rom_addr), 32'o4000);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch unit that replaces the single fetch-stage PC register with a PC generator plus a DEPTH-entry instruction queue. It sits between the synchronous 1-cycle program ROM and the decode stage. It keeps the ROM busy while decode is stalled, and squashes all queued and in-flight fetches on an execute-stage branch redirect. Decode consumes entries through a valid/ready handshake; `instr_ready` low is the decode stall.

## Interface
- `PC_W`, default 12: program-counter width.
- `INSTR_W`, default 15: instruction word width.
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `RESET_PC`, default 'o4000: PC value after reset.

Ports:
- `clock`  in  1  the single clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `rom_addr`  out  PC_W  fetch address, equal to `fetch_pc`.
- `rom_req`  out  1  a fetch of `rom_addr` is issued this cycle.
- `rom_data`  in  INSTR_W  ROM word for the address requested in the previous cycle.
- `redirect`  in  1  taken branch from execute.
- `redirect_pc`  in  PC_W  branch target.
- `hold`  in  1  halt; no new fetches are issued while high.
- `instr_valid`  out  1  head entry is presentable.
- `instr`  out  INSTR_W  head instruction.
- `instr_pc`  out  PC_W  PC of the head instruction.
- `instr_ready`  in  1  decode accepts the head entry.
- `count`  out  $clog2(DEPTH+1)  number of queued entries.

## Operation
- State:
  - `fetch_pc`;
  - `inflight` (1 bit) and `inflight_pc`;
  - circular storage of {instr, pc}, with `rd_ptr` and `wr_ptr` (mod DEPTH) and `count`.
- pop = `instr_valid` & `instr_ready`.
- `instr_valid` = (`count` != 0) & ~`redirect`.
- `instr` and `instr_pc` come from the `rd_ptr` entry. There is no bypass from `rom_data`.
- Credit rule: `rom_req` = ~`redirect` & ~`hold` & (`count` + `inflight` − pop < DEPTH). This rule means the queue never overflows.
- On `rom_req`:
  - `fetch_pc` <= `fetch_pc` + 1, modulo 2^PC_W, so 'o7777 (all ones) wraps to 0;
  - `inflight` <= 1 and `inflight_pc` <= `fetch_pc`.
- When there is no `rom_req`, `inflight` <= 0.
- Landing: if `inflight` & ~`redirect`, {`rom_data`, `inflight_pc`} is written at `wr_ptr`, then `wr_ptr`++.
- Count update:
  - push and pop in the same cycle leave `count` unchanged;
  - push alone increments it;
  - pop alone decrements it.
- Redirect takes precedence over every other event in its cycle:
  - `count`, `rd_ptr` and `wr_ptr` <= 0;
  - the landing word is discarded;
  - no pop occurs, because `instr_valid` is 0;
  - `rom_req` = 0;
  - `fetch_pc` <= `redirect_pc`.
- Hold:
  - no new requests are issued;
  - a request already in flight still lands;
  - pops continue;
  - fetching resumes at `fetch_pc` when `hold` falls.
  - `redirect` during `hold` still updates `fetch_pc` and flushes the queue.
- Reset (asynchronous, may occur mid-operation):
  - `fetch_pc` = RESET_PC;
  - `inflight`, `count` and both pointers = 0;
  - storage = 0.
- Outputs under reset:
  - `instr_valid` = 0, `count` = 0, `instr` = 0, `instr_pc` = 0, `rom_addr` = RESET_PC;
  - `rom_req` = ~`hold`.

## Timing
- `rom_addr` and `rom_req` are combinational from registered state plus `redirect`, `hold` and `instr_ready`. ROM data returns one cycle after the request.
- Fetch latency: a request in cycle t returns data in t+1; that data is written at the end of t+1 and is visible on `instr` with `instr_valid` = 1 in t+2.
- Throughput with `instr_ready` held at 1 is one instruction per cycle for any DEPTH of 2 or more.
- Redirect in cycle r:
  - `instr_valid` = 0 in cycles r, r+1 and r+2;
  - the target is requested in r+1;
  - `instr_pc` = `redirect_pc` with valid = 1 in r+3.
- `count` changes only at clock edges, except on asynchronous reset.

## Test plan
- Reset release with ready = 1 and DEPTH = 4 → `rom_addr` 'o4000 in cycle 0; `instr_valid` from cycle 2 with `instr_pc` 'o4000, 'o4001, 'o4002, … one per cycle, each `instr` matching the ROM model.
- `instr_ready` = 0 for 10 cycles after reset → exactly 4 requests issued, then `rom_req` = 0 with `count` = 4. On release, PCs 'o4000… arrive contiguously with no gap or duplicate, and `rom_req` reasserts in the first pop cycle.
- Queue full with a request in flight, then `redirect` with `redirect_pc` = 'o2000 → `count` = 0 the next cycle, `instr_valid` low for 3 cycles, next `instr_pc` = 'o2000. No word from the old stream ever appears.
- Redirect to 'o7776 → `instr_pc` sequence 'o7776, 'o7777, 'o0000, 'o0001.
- `hold` = 1 with ready = 1 from a steady stream → one in-flight word lands, the queue drains to `count` = 0 and `rom_req` stays 0. After release, the next `instr_pc` is the last issued PC + 1.
- `reset_n` low mid-stream with `count` = 3 → `instr_valid` = 0, `count` = 0 and `rom_addr` = 'o4000 before the next edge. Repeat the first scenario with DEPTH = 2.
